// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg: shared widths, constants and FSM encoding for the memory bus bridge
package mem_bus_bridge_pkg;
  localparam int REG_BUS = 64;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam int DEFAULT_TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: valid/ready request/response bus between the bridge and the memory slave
interface mem_bus_bridge_if
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = REG_BUS,
  parameter int DATA_W = REG_BUS
);
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mask_to_strb.sv
// mask_to_strb: reduces a bit-granular byte-aligned mask to one strobe per byte lane
module mask_to_strb #(
  parameter int DATA_W = 64
) (
  input logic [DATA_W-1:0] mask,
  output logic [DATA_W/8-1:0] strb
);
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign strb[i] = |mask[8*i+:8];
  end
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns single-cycle RAM strobes into a bounded valid/ready bus transaction
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = REG_BUS,
  parameter int DATA_W = REG_BUS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic clk,
  input logic rst,
  input logic [ADDR_W-1:0] ram_addr,
  input logic ram_r_ena,
  input logic ram_w_ena,
  input logic [DATA_W-1:0] ram_w_mask,
  input logic [DATA_W-1:0] ram_w_data,
  output logic [DATA_W-1:0] ram_r_data,
  output logic mem_stall,
  output logic mem_bus_err,
  mem_bus_bridge_if.master bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_sat;
  logic [DATA_W/8-1:0] strb;
  logic req;
  logic hit;
  logic unused_low;
  mask_to_strb #(.DATA_W(DATA_W)) u_strb (.mask(ram_w_mask), .strb(strb));
  assign unused_low = ^ram_addr[2:0];
  assign req = ram_r_ena | ram_w_ena;
  assign cnt_sat = cnt == T_MAX ? cnt : cnt + 1'b1;
  assign hit = (TIMEOUT != 0) && (cnt >= T_LAST);
  assign mem_stall = !rst && ((state == IDLE && req) || state == REQ || state == RSP);
  // Transaction FSM: latch the request, handshake, capture the response, bound the wait
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.req_valid <= 1'b0;
      bus.rsp_ready <= 1'b0;
      bus.req_addr <= '0;
      bus.req_wen <= 1'b0;
      bus.req_wdata <= '0;
      bus.req_wstrb <= '0;
      ram_r_data <= '0;
      mem_bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= REQ;
          cnt <= '0;
          bus.req_valid <= 1'b1;
          bus.req_addr <= {ram_addr[ADDR_W-1:3], 3'b000};
          bus.req_wen <= ram_w_ena;
          bus.req_wdata <= ram_w_data;
          bus.req_wstrb <= ram_w_ena ? strb : '0;
        end
        REQ: begin
          cnt <= cnt_sat;
          if (bus.req_valid && bus.req_ready) begin
            state <= RSP;
            bus.req_valid <= 1'b0;
            bus.rsp_ready <= 1'b1;
          end else if (hit) begin
            state <= DONE;
            bus.req_valid <= 1'b0;
            mem_bus_err <= 1'b1;
            if (!bus.req_wen) ram_r_data <= '0;
          end
        end
        RSP: begin
          cnt <= cnt_sat;
          if (bus.rsp_valid) begin
            state <= DONE;
            bus.rsp_ready <= 1'b0;
            mem_bus_err <= bus.rsp_err;
            if (!bus.req_wen) ram_r_data <= bus.rsp_err ? '0 : bus.rsp_rdata;
          end else if (hit) begin
            state <= DONE;
            bus.rsp_ready <= 1'b0;
            mem_bus_err <= 1'b1;
            if (!bus.req_wen) ram_r_data <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          mem_bus_err <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed vector table plus multi-cycle corner sequences for mem_bus_bridge
module tb_mem_bus_bridge;
  typedef struct {
    logic r, w;
    logic [63:0] addr, mask, wdata, rdata;
    logic err;
    logic [63:0] e_addr;
    logic e_wen;
    logic [7:0] e_strb;
    logic [63:0] e_rdata;
    logic e_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [63:0] ram_addr = '0;
  logic ram_r_ena = 1'b0;
  logic ram_w_ena = 1'b0;
  logic [63:0] ram_w_mask = '0;
  logic [63:0] ram_w_data = '0;
  logic [63:0] ram_r_data;
  logic mem_stall;
  logic mem_bus_err;
  logic ram2_r_ena = 1'b0;
  logic ram2_w_ena = 1'b0;
  logic [63:0] ram2_r_data;
  logic stall2;
  logic err2;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[9];
  mem_bus_bridge_if #(.ADDR_W(64), .DATA_W(64)) bus ();
  mem_bus_bridge_if #(.ADDR_W(64), .DATA_W(64)) bus2 ();
  mem_bus_bridge dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_r_ena(ram_r_ena), .ram_w_ena(ram_w_ena),
    .ram_w_mask(ram_w_mask), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
    .mem_stall(mem_stall), .mem_bus_err(mem_bus_err), .bus(bus)
  );
  mem_bus_bridge #(.TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_r_ena(ram2_r_ena), .ram_w_ena(ram2_w_ena),
    .ram_w_mask(ram_w_mask), .ram_w_data(ram_w_data), .ram_r_data(ram2_r_data),
    .mem_stall(stall2), .mem_bus_err(err2), .bus(bus2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ram_r_ena = v.r;
    ram_w_ena = v.w;
    ram_addr = v.addr;
    ram_w_mask = v.mask;
    ram_w_data = v.wdata;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = v.rdata;
    bus.rsp_err = v.err;
    #1 chk("stall_idle", mem_stall, 1);
    @(negedge clk);
    chk("req_valid", bus.req_valid, 1);
    chk("req_addr", bus.req_addr, v.e_addr);
    chk("req_wen", bus.req_wen, v.e_wen);
    chk("req_wstrb", bus.req_wstrb, v.e_strb);
    chk("req_wdata", bus.req_wdata, v.wdata);
    chk("stall_req", mem_stall, 1);
    @(negedge clk);
    chk("rsp_ready", bus.rsp_ready, 1);
    chk("req_valid_rsp", bus.req_valid, 0);
    chk("stall_rsp", mem_stall, 1);
    @(negedge clk);
    chk("stall_done", mem_stall, 0);
    chk("err_done", mem_bus_err, v.e_err);
    chk("rdata_done", ram_r_data, v.e_rdata);
    ram_r_ena = 1'b0;
    ram_w_ena = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse_end", mem_bus_err, 0);
    chk("stall_idle_after", mem_stall, 0);
  endtask
  initial begin
    vecs[0] = '{1, 0, 64'h8000_0013, 64'h0, 64'h0, 64'h1122334455667788, 0,
                64'h8000_0010, 0, 8'h00, 64'h1122334455667788, 0};
    vecs[1] = '{0, 1, 64'h8000_0022, 64'h0000_0000_00FF_0000, 64'h0000_0000_00AB_0000, 64'hFFFF_0000_FFFF_0000, 0,
                64'h8000_0020, 1, 8'h04, 64'h1122334455667788, 0};
    vecs[2] = '{1, 0, 64'h100, 64'h0, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 1,
                64'h100, 0, 8'h00, 64'h0, 1};
    vecs[3] = '{1, 0, 64'h1007, 64'hFFFF, 64'h3333, 64'hCAFE_BABE_0BAD_F00D, 0,
                64'h1000, 0, 8'h00, 64'hCAFE_BABE_0BAD_F00D, 0};
    vecs[4] = '{0, 1, 64'h2008, 64'h0, 64'h5555_5555_5555_5555, 64'h0, 0,
                64'h2008, 1, 8'h00, 64'hCAFE_BABE_0BAD_F00D, 0};
    vecs[5] = '{1, 1, 64'h3003, 64'hFF00_0000_0000_00FF, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                64'h3000, 1, 8'h81, 64'hCAFE_BABE_0BAD_F00D, 0};
    vecs[6] = '{0, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1,
                64'h40, 1, 8'hFF, 64'hCAFE_BABE_0BAD_F00D, 1};
    vecs[7] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
                64'hFFFF_FFFF_FFFF_FFF8, 0, 8'h00, 64'h0123_4567_89AB_CDEF, 0};
    vecs[8] = '{1, 0, 64'h7777, 64'h0, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 0,
                64'h7770, 0, 8'h00, 64'h0F0E_0D0C_0B0A_0908, 0};
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err = 1'b0;
    bus2.req_ready = 1'b0;
    bus2.rsp_valid = 1'b0;
    bus2.rsp_rdata = '0;
    bus2.rsp_err = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_rsp_ready", bus.rsp_ready, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_err", mem_bus_err, 0);
    chk("rst_rdata", ram_r_data, 0);
    chk("rst_req_addr", bus.req_addr, 0);
    chk("rst_req_wen", bus.req_wen, 0);
    chk("rst_req_wdata", bus.req_wdata, 0);
    chk("rst_req_wstrb", bus.req_wstrb, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    // backpressure: req_ready low 5 cycles, response 3 cycles late
    @(negedge clk);
    ram_r_ena = 1'b1;
    ram_addr = 64'h5013;
    ram_w_data = 64'h4444;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 64'hA5A5_A5A5_5A5A_5A5A;
    bus.rsp_err = 1'b0;
    #1 chk("bp_stall_idle", mem_stall, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ram_addr = 64'h9990 + 64'(i);
      chk("bp_req_valid", bus.req_valid, 1);
      chk("bp_req_addr", bus.req_addr, 64'h5010);
      chk("bp_req_wdata", bus.req_wdata, 64'h4444);
      chk("bp_stall_req", mem_stall, 1);
      if (i == 5) begin
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_ready", bus.rsp_ready, 1);
      chk("bp_req_valid_rsp", bus.req_valid, 0);
      chk("bp_req_addr_rsp", bus.req_addr, 64'h5010);
      chk("bp_stall_rsp", mem_stall, 1);
      if (i == 3) bus.rsp_valid = 1'b1;
    end
    @(negedge clk);
    chk("bp_stall_done", mem_stall, 0);
    chk("bp_rdata", ram_r_data, 64'hA5A5_A5A5_5A5A_5A5A);
    chk("bp_err", mem_bus_err, 0);
    ram_r_ena = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    // back-to-back reads with the enable held
    @(negedge clk);
    ram_r_ena = 1'b1;
    ram_addr = 64'h9000;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 64'h1111_1111_1111_1111;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done1_stall", mem_stall, 0);
    chk("b2b_rdata1", ram_r_data, 64'h1111_1111_1111_1111);
    bus.rsp_rdata = 64'h2222_2222_2222_2222;
    @(negedge clk);
    chk("b2b_idle_stall", mem_stall, 1);
    chk("b2b_idle_valid", bus.req_valid, 0);
    @(negedge clk);
    chk("b2b_req2_valid", bus.req_valid, 1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done2_stall", mem_stall, 0);
    chk("b2b_rdata2", ram_r_data, 64'h2222_2222_2222_2222);
    ram_r_ena = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    // asynchronous reset while waiting in RSP
    @(negedge clk);
    ram_r_ena = 1'b1;
    ram_addr = 64'h6018;
    ram_w_data = 64'h6666;
    bus.req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rr_rsp_ready", bus.rsp_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_rsp_ready0", bus.rsp_ready, 0);
    chk("rr_req_valid0", bus.req_valid, 0);
    chk("rr_stall0", mem_stall, 0);
    chk("rr_err0", mem_bus_err, 0);
    chk("rr_rdata0", ram_r_data, 0);
    chk("rr_addr0", bus.req_addr, 0);
    chk("rr_wdata0", bus.req_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    ram_r_ena = 1'b0;
    bus.req_ready = 1'b0;
    run_vec(vecs[8]);
    // timeout instance: one good read, then req_ready stuck low
    @(negedge clk);
    ram2_r_ena = 1'b1;
    ram_addr = 64'hA000;
    bus2.req_ready = 1'b1;
    bus2.rsp_valid = 1'b1;
    bus2.rsp_rdata = 64'h7766_5544_3322_1100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("to_pre_rdata", ram2_r_data, 64'h7766_5544_3322_1100);
    ram2_r_ena = 1'b0;
    bus2.req_ready = 1'b0;
    bus2.rsp_valid = 1'b0;
    @(negedge clk);
    ram2_r_ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_valid", bus2.req_valid, 1);
      chk("to_stall", stall2, 1);
    end
    @(negedge clk);
    chk("to_abort_valid", bus2.req_valid, 0);
    chk("to_err", err2, 1);
    chk("to_rdata", ram2_r_data, 0);
    chk("to_stall_done", stall2, 0);
    ram2_r_ena = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", err2, 0);
    chk("to_idle_stall", stall2, 0);
    chk("to_idle_valid", bus2.req_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
